// File: rtl/alu_sequencer.sv
// Three-state sequencer that feeds an external ALU from an 8-bit accumulator.
// LOAD and illegal opcodes complete in IDLE; ALU ops go through ISSUE and CAPTURE.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [3:0] alu_operacao,
  output logic [7:0] alu_operA,
  output logic [7:0] alu_operB,
  output logic       alu_Cin,
  input  logic [7:0] alu_result,
  input  logic       alu_N,
  input  logic       alu_Z,
  input  logic       alu_C,
  input  logic       alu_B,
  input  logic       alu_V,
  output logic [7:0] acc,
  output logic       flag_N,
  output logic       flag_Z,
  output logic       flag_C,
  output logic       flag_B,
  output logic       flag_V,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  typedef enum logic [3:0] {
    OP_LOAD = 4'h0, OP_ADIC = 4'h1, OP_SUB = 4'h2, OP_OU  = 4'h3, OP_E   = 4'h4,
    OP_NAO  = 4'h5, OP_DLE  = 4'h6, OP_DLD = 4'h7, OP_DAE = 4'h8, OP_DAD = 4'h9
  } op_t;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic [7:0] acc_q, acc_d;
  logic       n_q, n_d, z_q, z_d, c_q, c_d, b_q, b_d, v_q, v_d;
  logic       done_q, done_d, err_q, err_d;
  logic       busy, shift_op;

  assign busy     = (state_q != IDLE);
  assign shift_op = (op_q >= OP_DLE) && (op_q <= OP_DAD);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    acc_d   = acc_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    b_d     = b_q;
    v_d     = v_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD) begin
            acc_d  = cmd_data;
            n_d    = cmd_data[7];
            z_d    = (cmd_data == '0);
            done_d = 1'b1;
          end else if (cmd_op <= OP_DAD) begin
            op_d    = cmd_op;
            data_d  = cmd_data;
            state_d = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        acc_d  = alu_result;
        n_d    = alu_N;
        z_d    = alu_Z;
        if (op_q == OP_ADIC || shift_op) c_d = alu_C;
        if (op_q == OP_SUB) b_d = alu_B;
        if (op_q == OP_ADIC || op_q == OP_SUB) v_d = alu_V;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      acc_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      b_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      b_q     <= b_d;
      v_q     <= v_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Carry flag only changes in CAPTURE, so alu_Cin stays stable across ISSUE/CAPTURE.
  assign cmd_ready    = (state_q == IDLE);
  assign alu_operacao = busy ? op_q : '0;
  assign alu_operA    = acc_q;
  assign alu_operB    = busy ? data_q : '0;
  assign alu_Cin      = busy && shift_op && c_q;

  assign acc    = acc_q;
  assign flag_N = n_q;
  assign flag_Z = z_q;
  assign flag_C = c_q;
  assign flag_B = b_q;
  assign flag_V = v_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU attached to its ALU port.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_data;
  logic [3:0] alu_operacao;
  logic [7:0] alu_operA, alu_operB, alu_result;
  logic       alu_Cin, alu_N, alu_Z, alu_C, alu_B, alu_V;
  logic [7:0] acc;
  logic       flag_N, flag_Z, flag_C, flag_B, flag_V;
  logic       done, err;
  logic [4:0] fl;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_operacao(alu_operacao), .alu_operA(alu_operA), .alu_operB(alu_operB),
    .alu_Cin(alu_Cin), .alu_result(alu_result),
    .alu_N(alu_N), .alu_Z(alu_Z), .alu_C(alu_C), .alu_B(alu_B), .alu_V(alu_V),
    .acc(acc), .flag_N(flag_N), .flag_Z(flag_Z), .flag_C(flag_C), .flag_B(flag_B),
    .flag_V(flag_V), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign fl = {flag_N, flag_Z, flag_C, flag_B, flag_V};

  // Returns {result[7:0], N, Z, C, B, V}
  function automatic logic [12:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, bo, v;
    c = 1'b0; bo = 1'b0; v = 1'b0; r = a; s = '0;
    case (op)
      4'h1: begin s = {1'b0, a} + {1'b0, b} + {8'h00, cin}; r = s[7:0]; c = s[8];
                  v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'h2: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; bo = s[8];
                  v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'h3: r = a | b;
      4'h4: r = a & b;
      4'h5: r = ~a;
      4'h6: begin r = {a[6:0], cin}; c = a[7]; end
      4'h7: begin r = {cin, a[7:1]}; c = a[0]; end
      4'h8: begin r = {a[6:0], cin}; c = a[7]; end
      4'h9: begin r = {a[7], a[7:1]}; c = a[0]; end
      default: r = a;
    endcase
    return {r, r[7], (r == 8'h00), c, bo, v};
  endfunction

  logic [12:0] alu_out;
  always_comb alu_out = alu_fn(alu_operacao, alu_operA, alu_operB, alu_Cin);
  assign {alu_result, alu_N, alu_Z, alu_C, alu_B, alu_V} = alu_out;

  typedef struct {
    bit          is_err;
    logic [7:0]  acc;
    logic [4:0]  fl;
    int unsigned lat;
    int unsigned t;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_mis = 0;
  logic [7:0] m_acc;
  logic [4:0] m_fl;   // {N,Z,C,B,V}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Retirement monitor: every done/err pulse must match the oldest pending command.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (done === 1'b1 || err === 1'b1)) begin
      if (sb.size() == 0) begin
        chk("spurious_pulse", {30'd0, done, err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
        chk("ret_acc", acc, e.acc);
        chk("ret_flags", fl, e.fl);
        chk("ret_latency", cyc - e.t, e.lat);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] d);
    exp_t        e;
    logic [12:0] r;
    logic [7:0]  prev_acc;
    logic        cin;
    int unsigned k;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      chk("accept_timeout", k, 0);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    prev_acc = m_acc;
    cin      = 1'b0;
    e.t      = cyc;
    e.is_err = 1'b0;
    e.lat    = 0;
    if (op == 4'h0) begin
      m_acc   = d;
      m_fl[4] = d[7];
      m_fl[3] = (d == 8'h00);
    end else if (op <= 4'h9) begin
      cin     = (op >= 4'h6) ? m_fl[2] : 1'b0;
      r       = alu_fn(op, m_acc, d, cin);
      m_acc   = r[12:5];
      m_fl[4] = r[4];
      m_fl[3] = r[3];
      if (op == 4'h1 || op >= 4'h6) m_fl[2] = r[2];
      if (op == 4'h2) m_fl[1] = r[1];
      if (op == 4'h1 || op == 4'h2) m_fl[0] = r[0];
      e.lat = 2;
    end else begin
      e.is_err = 1'b1;
    end
    e.acc = m_acc;
    e.fl  = m_fl;
    sb.push_back(e);
    cmd_valid = 1'b0;
    @(negedge clk);
    if (op >= 4'h1 && op <= 4'h9) begin
      chk("issue_op", alu_operacao, op);
      chk("issue_a", alu_operA, prev_acc);
      chk("issue_b", alu_operB, d);
      chk("issue_cin", alu_Cin, cin);
      chk("busy_ready", cmd_ready, 0);
    end
  endtask

  task automatic drain();
    int unsigned k;
    k = 0;
    while (sb.size() > 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    m_acc     = '0;
    m_fl      = '0;
    #12;
    chk("rst_acc", acc, 0);
    chk("rst_flags", fl, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_op", alu_operacao, 0);
    chk("rst_b", alu_operB, 0);
    chk("rst_cin", alu_Cin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    send(4'h0, 8'd10);  send(4'h1, 8'd20);  drain();
    chk("v33_acc", acc, 30);
    chk("v33_flags", fl, 5'b00000);

    send(4'h0, 8'd255); send(4'h1, 8'd1);   drain();
    chk("v34_acc", acc, 0);
    chk("v34_flags", fl, 5'b01100);

    send(4'h0, 8'd0);   send(4'h2, 8'd1);   drain();
    chk("v35_acc", acc, 255);
    chk("v35_flags", fl, 5'b10110);

    send(4'h0, 8'd129); send(4'h6, 8'd0);   drain();
    chk("v36_acc", acc, 3);
    chk("v36_flags", fl, 5'b00110);

    send(4'hF, 8'd7);   drain();
    chk("v37_acc", acc, 3);
    chk("v37_flags", fl, 5'b00110);

    // back-to-back: cmd_valid reasserted while the sequencer is busy
    send(4'h1, 8'd5);   send(4'h2, 8'd3);   send(4'hE, 8'd0);  send(4'h0, 8'd42);
    send(4'h7, 8'd0);   send(4'h3, 8'd8);   send(4'h4, 8'hF0); send(4'h5, 8'd0);
    send(4'h8, 8'd0);   send(4'h9, 8'd0);   drain();

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      logic [7:0] d;
      op = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      send(op, d);
    end
    drain();

    // reset during CAPTURE of an ADIC
    send(4'h0, 8'd50);  drain();
    send(4'h1, 8'd9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_acc = '0;
    m_fl  = '0;
    chk("abort_acc", acc, 0);
    chk("abort_flags", fl, 0);
    chk("abort_done", done, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_no_done", done, 0);
    chk("abort_acc_after", acc, 0);
    send(4'h0, 8'd1);   drain();

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 cmd_valid  input  1  command present.
REQ-004 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-005 cmd_op  input  4  0000 LOAD, 0001 ADIC, 0010 SUB, 0011 OU, 0100 E, 0101 NAO, 0110 DLE, 0111 DLD, 1000 DAE, 1001 DAD; 1010-1111 illegal.
REQ-006 cmd_data  input  8  operand; operB for ALU ops, load value for LOAD.
REQ-007 alu_operacao  output  4  to ALU operacao.
REQ-008 alu_operA  output  8  to ALU operA; always the accumulator.
REQ-009 alu_operB  output  8  to ALU operB.
REQ-010 alu_Cin  output  1  to ALU Cin.
REQ-011 alu_result  input  8  ALU result.
REQ-012 alu_N, alu_Z, alu_C, alu_B, alu_V  input  1 each  ALU flags.
REQ-013 acc  output  8  accumulator.
REQ-014 flag_N, flag_Z, flag_C, flag_B, flag_V  output  1 each  registered flags.
REQ-015 done  output  1  one-cycle pulse: command retired.
REQ-016 err  output  1  one-cycle pulse: illegal opcode rejected.

Function
REQ-017 FSM states IDLE, ISSUE, CAPTURE; cmd_ready = 1 only in IDLE.
REQ-018 Handshake: accept on cmd_valid && cmd_ready; cmd_op/cmd_data registered at acceptance; inputs ignored outside IDLE.
REQ-019 IDLE + accepted legal ALU op (0001-1001) -> ISSUE; ISSUE -> CAPTURE unconditionally; CAPTURE -> IDLE unconditionally.
REQ-020 In ISSUE and CAPTURE, alu_operacao/operA/operB/Cin driven from registered command and held stable; in IDLE alu_operacao = 0000, alu_operB = 0.
REQ-021 alu_Cin = flag_C for ops 0110-1001; 0 for all other ops.
REQ-022 In CAPTURE: acc <= alu_result; done = 1; flags updated per REQ-023, others held.
REQ-023 Flag update: ADIC N,Z,C,V; SUB N,Z,B,V; OU/E/NAO N,Z; DLE/DLD/DAE/DAD N,Z,C.
REQ-024 ALU op latency: command accepted at edge T -> acc/flags valid and done high in cycle after edge T+2; next command accepted at edge T+3 earliest.
REQ-025 LOAD: handled in IDLE, no ALU use; acc <= cmd_data, flag_N <= cmd_data[7], flag_Z <= (cmd_data == 0), C/B/V held; done pulses cycle after acceptance; stays IDLE.
REQ-026 Illegal op: accepted (handshake completes), err pulses next cycle, acc and flags unchanged, no done, stays IDLE.
REQ-027 done and err never asserted together; each exactly one cycle.
REQ-028 Back-to-back: cmd_valid held high while busy is not lost; accepted at next IDLE cycle.
REQ-029 Arithmetic widths: all data 8-bit; no sign extension; result wrap handled solely by ALU.

Reset
REQ-030 rst_n low: immediately state = IDLE, acc = 0, all flags = 0, done = 0, err = 0, alu_operacao = 0000, alu_operB = 0, alu_Cin = 0.
REQ-031 Reset asserted in ISSUE/CAPTURE aborts command: no done, acc/flags take reset values.
REQ-032 After rst_n rises, cmd_ready = 1 at first clock edge.

Verification
REQ-033 LOAD 10, then ADIC 20 -> acc = 30, N=Z=C=B=V=0, done exactly 2 cycles after ADIC acceptance, alu_Cin = 0.
REQ-034 LOAD 255, ADIC 1 -> acc = 0, Z = 1, C = 1, N = 0, V = 0.
REQ-035 Continue: LOAD 0 (C stays 1), SUB 1 -> acc = 255, N = 1, B = 1, Z = 0, C still 1.
REQ-036 Continue: LOAD 129, DLE with flag_C = 1 -> alu_Cin = 1, acc = 3, C = 1, N = 0, Z = 0.
REQ-037 cmd_op = 1111, cmd_data = 7 -> err pulse, no done, acc/flags unchanged; cmd_valid held through busy cycles -> each command retired once.
REQ-038 rst_n pulsed low during CAPTURE of ADIC -> no done, acc = 0, flags = 0, cmd_ready = 1 after release.
